// File: rtl/scroll_controller_pkg.sv
// rtl/scroll_controller_pkg.sv - shared game types and speed encoding
package scroll_controller_pkg;

    localparam int GAME_SUBPIX_BITS = 6;
    localparam int GAME_SPEED_W     = 10;
    localparam int GAME_SPEED_MAX   = 512;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FINISH = 2'd1,
        ST_DONE   = 2'd2
    } scroll_state_t;

endpackage

// File: rtl/subpixel_accumulator.sv
// rtl/subpixel_accumulator.sv - per-frame sub-pixel speed integrator
module subpixel_accumulator
    import scroll_controller_pkg::*;
#(
    parameter int SUBPIX_BITS = GAME_SUBPIX_BITS
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    advance,
    input  logic                    clear,
    input  logic [GAME_SPEED_W-1:0] speed,
    output logic [GAME_SPEED_W:0]   px
);

    localparam int SUM_W = GAME_SPEED_W + 1;
    localparam logic [GAME_SPEED_W-1:0] SPEED_CAP = GAME_SPEED_W'(GAME_SPEED_MAX);

    logic [SUBPIX_BITS-1:0]  frac_q;
    logic [GAME_SPEED_W-1:0] speed_c;
    logic [SUM_W-1:0]        sum;

    // Out-of-range speed codes are clamped so px never exceeds the road's assumptions.
    always_comb begin
        speed_c = (speed > SPEED_CAP) ? SPEED_CAP : speed;
        sum     = {1'b0, speed_c} + SUM_W'(frac_q);
        px      = sum >> SUBPIX_BITS;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frac_q <= '0;
        end else if (clear) begin
            frac_q <= '0;
        end else if (advance) begin
            frac_q <= sum[SUBPIX_BITS-1:0];
        end
    end

endmodule

// File: rtl/scroll_controller.sv
// rtl/scroll_controller.sv - road scroll, distance and finish-line sequencing
module scroll_controller
    import scroll_controller_pkg::*;
#(
    parameter int TRACK_LENGTH = 16000,
    parameter int SCREEN_H     = 480,
    parameter int PLAYER_Y     = 380,
    parameter int SUBPIX_BITS  = GAME_SUBPIX_BITS,
    parameter int ROW_H        = 64
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        frame_start,
    input  logic        restart,
    input  logic [9:0]  player_speed,
    output logic [10:0] scroll_y,
    output logic [15:0] distance,
    output logic        finish_visible,
    output logic [10:0] finish_y,
    output logic        new_row,
    output logic        race_done
);

    localparam logic [15:0] FIN_START = 16'(TRACK_LENGTH - PLAYER_Y);
    localparam logic [16:0] DIST_CAP  = 17'(TRACK_LENGTH + SCREEN_H - PLAYER_Y);
    localparam logic [11:0] WRAP      = 12'(SCREEN_H);
    localparam logic [16:0] ROW_PITCH = 17'(ROW_H);

    scroll_state_t state_q, state_d;

    logic [10:0] px;
    logic [16:0] dist_sum;
    logic [15:0] dist_next;
    logic [11:0] scroll_sum;
    logic [10:0] scroll_next;
    logic [15:0] row_pos;
    logic [16:0] row_sum;
    logic [15:0] row_next;
    logic        row_cross;
    logic [10:0] finish_y_next;

    subpixel_accumulator #(
        .SUBPIX_BITS (SUBPIX_BITS)
    ) u_accum (
        .clk     (clk),
        .resetN  (resetN),
        .advance (frame_start),
        .clear   (restart),
        .speed   (player_speed),
        .px      (px)
    );

    always_comb begin
        dist_sum = {1'b0, distance} + 17'(px);
        if (state_q == ST_DONE) begin
            dist_next = distance;
        end else if (dist_sum > DIST_CAP) begin
            dist_next = DIST_CAP[15:0];
        end else begin
            dist_next = dist_sum[15:0];
        end

        scroll_sum  = {1'b0, scroll_y} + 12'(px);
        scroll_next = (scroll_sum >= WRAP) ? 11'(scroll_sum - WRAP) : scroll_sum[10:0];

        // row_pos tracks distance mod ROW_H so no divider is needed for the spawn pulse.
        row_sum   = {1'b0, row_pos} + {1'b0, dist_next - distance};
        row_cross = (state_q != ST_DONE) && (row_sum >= ROW_PITCH);
        row_next  = row_cross ? 16'(row_sum - ROW_PITCH) : row_sum[15:0];

        finish_y_next = 11'(dist_next - FIN_START);

        // Reaching the cap is the same event as the finish line leaving the screen.
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if ({1'b0, dist_next} >= DIST_CAP) begin
                    state_d = ST_DONE;
                end else if (dist_next >= FIN_START) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                if ({1'b0, dist_next} >= DIST_CAP) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:   state_d = ST_DONE;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_RUN;
        end else if (restart) begin
            state_q <= ST_RUN;
        end else if (frame_start) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            scroll_y       <= '0;
            distance       <= '0;
            row_pos        <= '0;
            finish_visible <= 1'b0;
            finish_y       <= '0;
            new_row        <= 1'b0;
            race_done      <= 1'b0;
        end else if (restart) begin
            scroll_y       <= '0;
            distance       <= '0;
            row_pos        <= '0;
            finish_visible <= 1'b0;
            finish_y       <= '0;
            new_row        <= 1'b0;
            race_done      <= 1'b0;
        end else begin
            new_row <= 1'b0;
            if (frame_start) begin
                scroll_y       <= scroll_next;
                distance       <= dist_next;
                row_pos        <= row_next;
                new_row        <= row_cross;
                finish_visible <= (state_d == ST_FINISH);
                finish_y       <= (state_d == ST_FINISH) ? finish_y_next : 11'd0;
                race_done      <= (state_d == ST_DONE);
            end
        end
    end

endmodule

// File: tb/tb_scroll_controller.sv
// tb/tb_scroll_controller.sv - randomized self-checking bench for scroll_controller
module tb_scroll_controller;

    localparam int TRACK_LENGTH = 16000;
    localparam int SCREEN_H     = 480;
    localparam int PLAYER_Y     = 380;
    localparam int SUBPIX       = 6;
    localparam int ROW_H        = 64;
    localparam int FIN_START    = TRACK_LENGTH - PLAYER_Y;
    localparam int DIST_CAP     = TRACK_LENGTH + SCREEN_H - PLAYER_Y;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        frame_start = 1'b0;
    logic        restart = 1'b0;
    logic [9:0]  player_speed = '0;
    logic [10:0] scroll_y;
    logic [15:0] distance;
    logic        finish_visible;
    logic [10:0] finish_y;
    logic        new_row;
    logic        race_done;

    int     checks = 0;
    int     errors = 0;
    longint m_sub = 0;

    always #5 clk = ~clk;

    scroll_controller #(
        .TRACK_LENGTH (TRACK_LENGTH),
        .SCREEN_H     (SCREEN_H),
        .PLAYER_Y     (PLAYER_Y),
        .SUBPIX_BITS  (SUBPIX),
        .ROW_H        (ROW_H)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .frame_start    (frame_start),
        .restart        (restart),
        .player_speed   (player_speed),
        .scroll_y       (scroll_y),
        .distance       (distance),
        .finish_visible (finish_visible),
        .finish_y       (finish_y),
        .new_row        (new_row),
        .race_done      (race_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: total sub-pixel travel; everything else follows arithmetically.
    function automatic longint m_dist();
        longint d = m_sub >>> SUBPIX;
        return (d > DIST_CAP) ? longint'(DIST_CAP) : d;
    endfunction

    task automatic check_state(input string tag, input bit exp_row);
        longint d = m_dist();
        bit     fv = (d >= FIN_START) && (d < DIST_CAP);
        check({tag, ".scroll"}, 64'(scroll_y), 64'((m_sub >>> SUBPIX) % SCREEN_H));
        check({tag, ".dist"}, 64'(distance), 64'(d));
        check({tag, ".frac"}, 64'(dut.u_accum.frac_q), 64'(m_sub % (1 << SUBPIX)));
        check({tag, ".fvis"}, 64'(finish_visible), 64'(fv));
        if (fv) check({tag, ".fy"}, 64'(finish_y), 64'(d - FIN_START));
        check({tag, ".done"}, 64'(race_done), 64'(d >= DIST_CAP));
        check({tag, ".row"}, 64'(new_row), 64'(exp_row));
    endtask

    task automatic frame(input int spd, input int gap, input string tag);
        longint d0 = m_dist();
        @(negedge clk);
        player_speed = 10'(spd);
        frame_start  = 1'b1;
        @(negedge clk);
        frame_start  = 1'b0;
        m_sub += spd;
        check_state(tag, (m_dist() / ROW_H) != (d0 / ROW_H));
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            check({tag, ".row_idle"}, 64'(new_row), 64'(0));
        end
    endtask

    task automatic do_restart(input bit with_frame, input string tag);
        @(negedge clk);
        restart      = 1'b1;
        frame_start  = with_frame;
        player_speed = 10'd512;
        @(negedge clk);
        restart      = 1'b0;
        frame_start  = 1'b0;
        m_sub        = 0;
        check_state(tag, 1'b0);
    endtask

    initial begin
        int     exp_px[4] = '{1, 2, 1, 2};
        int     prev;
        int     spd;
        longint scroll_hold;

        repeat (3) @(negedge clk);
        check_state("reset", 1'b0);
        resetN = 1'b1;

        for (int i = 0; i < 10; i++) frame(64, 1, "s64");
        check("s64.dist_final", 64'(distance), 64'(10));
        check("s64.scroll_final", 64'(scroll_y), 64'(10));
        check("s64.frac_final", 64'(dut.u_accum.frac_q), 64'(0));

        do_restart(1'b0, "rst34");
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            frame(100, 0, "s100");
            check("s100.px", 64'(int'(distance) - prev), 64'(exp_px[i]));
            prev = int'(distance);
        end
        check("s100.dist_final", 64'(distance), 64'(6));
        check("s100.frac_final", 64'(dut.u_accum.frac_q), 64'(16));

        do_restart(1'b0, "rst35a");
        for (int i = 0; i < 7; i++) frame(512, 0, "row");
        frame(512, 0, "row64");
        check("row64.pulse", 64'(new_row), 64'(1));
        @(negedge clk);
        check("row64.single", 64'(new_row), 64'(0));

        do_restart(1'b0, "rst35b");
        for (int i = 0; i < 119; i++) frame(256, 0, "pre476");
        check("wrap.pre", 64'(scroll_y), 64'(476));
        frame(512, 0, "wrap");
        check("wrap.post", 64'(scroll_y), 64'(4));

        do_restart(1'b0, "rst_rand");
        for (int i = 0; i < 400; i++) begin
            spd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 512));
            frame(spd, int'($urandom_range(0, 2)), "rand");
        end

        do_restart(1'b0, "rst36");
        for (int i = 0; i < 1952; i++) frame(512, 0, "run");
        check("fin.pre_dist", 64'(distance), 64'(15616));
        check("fin.pre_vis", 64'(finish_visible), 64'(0));
        frame(512, 0, "fin_enter");
        check("fin.enter_dist", 64'(distance), 64'(15624));
        check("fin.enter_vis", 64'(finish_visible), 64'(1));
        check("fin.enter_y", 64'(finish_y), 64'(4));
        for (int i = 0; i < 47; i++) frame(512, 0, "fin");
        check("fin.track_dist", 64'(distance), 64'(16000));
        check("fin.track_y", 64'(finish_y), 64'(380));
        for (int i = 0; i < 13; i++) frame(512, 0, "fin_exit");
        check("done.dist", 64'(distance), 64'(16100));
        check("done.flag", 64'(race_done), 64'(1));
        check("done.vis", 64'(finish_visible), 64'(0));
        for (int i = 0; i < 5; i++) frame(int'($urandom_range(1, 512)), 1, "done");
        scroll_hold = longint'(scroll_y);
        frame(0, 0, "done_stop");
        check("done.stopped", 64'(scroll_y), 64'(scroll_hold));

        do_restart(1'b0, "rst37");
        for (int i = 0; i < 1953; i++) frame(512, 0, "run37");
        check("r37.in_finish", 64'(finish_visible), 64'(1));
        do_restart(1'b1, "r37.collide");
        frame(512, 0, "r37.first");
        check("r37.first_dist", 64'(distance), 64'(8));

        for (int i = 0; i < 20; i++) frame(512, 0, "run38");
        @(negedge clk);
        player_speed = 10'd512;
        frame_start  = 1'b1;
        #2 resetN = 1'b0;
        #1 m_sub = 0;
        check_state("async_rst", 1'b0);
        @(negedge clk);
        frame_start = 1'b0;
        check_state("async_hold", 1'b0);
        resetN = 1'b1;
        frame(512, 0, "r38.first");
        check("r38.first_dist", 64'(distance), 64'(8));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
